intersection_controller: RTL
============================

Name: intersection_controller

Overview:
- Sequences two traffic-light approaches, north-south (NS) and east-west (EW), sharing one intersection.
- Inserts an all-red clearance between approaches and serves a latched pedestrian request as an all-red WALK phase.
- Rests on the current green when the crossing approach has no demand.
- Sits above the per-approach lamp drivers and is the only block allowed to grant green.

Parameters:
- GREEN_CYC, 10, minimum green duration in clk cycles (>=1).
- YELLOW_CYC, 3, yellow duration in cycles (>=1).
- ALLRED_CYC, 2, all-red clearance duration in cycles (>=1).
- WALK_CYC, 6, pedestrian walk duration in cycles (>=1).
- CNT_W, 8, phase counter width; must hold max(parameter) - 1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = sequencer advances; 0 = freeze state and counter.
- sense_ns  in  1  vehicle demand on NS, level.
- sense_ew  in  1  vehicle demand on EW, level.
- ped_req  in  1  pedestrian button; a one-cycle pulse is sufficient.
- ns_red, ns_yellow, ns_green  out  1 each  NS lamps.
- ew_red, ew_yellow, ew_green  out  1 each  EW lamps.
- walk  out  1  pedestrian walk lamp.
- ped_pending  out  1  latched pedestrian request.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on reset_n.
- States: CLR_NS, WALK_NS, NS_GRN, NS_YEL, CLR_EW, WALK_EW, EW_GRN, EW_YEL. Encoding is free.
- Reset (immediately on reset_n=0, including mid-phase):
  - state = CLR_NS; cnt = ALLRED_CYC-1; ped_pending = 0.
  - ns_red = ew_red = 1; all yellow and green lamps = 0; walk = 0.
- Outputs: Moore, registered, decoded from state. Lamps change on the same edge as the state.
- Phase counter:
  - On each state entry, cnt loads that state's duration minus 1.
  - Each enabled cycle, cnt decrements while nonzero.
  - Phase expires when cnt==0 at an enabled edge, so a state lasts exactly N enabled cycles.
- Transitions, evaluated only on an enabled edge with cnt==0:
  - CLR_NS: go to WALK_NS if ped_pending, else NS_GRN.
  - WALK_NS: go to NS_GRN.
  - NS_GRN: go to NS_YEL if (sense_ew | ped_pending); otherwise hold with cnt=0. Demand arriving later moves to NS_YEL on the next enabled edge.
  - NS_YEL: go to CLR_EW.
  - CLR_EW, WALK_EW, EW_GRN, EW_YEL: mirror of the above with NS and EW swapped. EW_GRN leaves on (sense_ns | ped_pending).
- Lamp decode:
  - NS_GRN: ns_green=1, ew_red=1.
  - NS_YEL: ns_yellow=1, ew_red=1.
  - EW_GRN / EW_YEL: symmetric.
  - CLR_*: both reds = 1.
  - WALK_*: both reds = 1 and walk=1.
- ped_pending:
  - Set by ped_req=1 in any state other than WALK_*, regardless of enable.
  - Cleared on the edge that enters WALK_*.
  - ped_req during WALK_* is ignored.
  - Set and clear on the same edge: clear wins only in WALK entry.
- enable=0: state, cnt and lamps hold. Sensors are not sampled; ped_req is still latched. Resuming continues with the remaining count.
- Invariants, every cycle:
  - Exactly one lamp of each approach's trio is 1.
  - Never both ns_red=0 and ew_red=0.
  - walk=1 only with both reds = 1.
- Simultaneous demand at NS_GRN expiry (sense_ew and ped_pending): yellow, then clearance, then WALK_EW, then EW_GRN.

Test Plan:
- Reset: reset_n=0 -> ns_red=ew_red=1, other lamps 0, walk=0, ped_pending=0. Reassert reset during NS_GRN cycle 4 -> same values immediately, without waiting for a clk edge.
- Idle rest: release reset, enable=1, sensors=0 -> CLR_NS for 2 cycles, then ns_green=1 held for 100 cycles with no yellow.
- Crossing traffic: sense_ew=1 throughout, sense_ns=0 -> NS green 10, NS yellow 3, all-red 2, ew_green from then on with no further change.
- Pedestrian: one-cycle ped_req at NS_GRN cycle 3, sensors=0 -> ped_pending=1 next edge. After green expiry: NS yellow 3, all-red 2, walk=1 with all red for 6 cycles (ped_pending=0 from first WALK cycle), then ew_green=1.
- Freeze: enable=0 for 5 cycles starting at NS_YEL cycle 2 -> ns_yellow stays 1. After resume, yellow lasts 2 more cycles (8 total), then all-red 2.
- Safety: 5000 cycles of random sense_*, ped_req, enable and occasional reset -> invariants never violated. Every green lasts >=10 enabled cycles and every yellow exactly 3.

Source files
------------

// File: rtl/intersection_controller.sv
// Two-approach traffic sequencer with all-red clearance and a latched pedestrian WALK phase.
// Rests on the current green until the crossing approach or a pedestrian asks for service.
module intersection_controller #(
    parameter int GREEN_CYC  = 10,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2,
    parameter int WALK_CYC   = 6,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic sense_ns,
    input  logic sense_ew,
    input  logic ped_req,
    output logic ns_red,
    output logic ns_yellow,
    output logic ns_green,
    output logic ew_red,
    output logic ew_yellow,
    output logic ew_green,
    output logic walk,
    output logic ped_pending
);

    typedef enum logic [2:0] {
        CLR_NS,
        WALK_NS,
        NS_GRN,
        NS_YEL,
        CLR_EW,
        WALK_EW,
        EW_GRN,
        EW_YEL
    } state_t;

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_CYC - 1);

    // Lamp vector order: ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk
    localparam logic [6:0] LAMPS_CLR  = 7'b100_100_0;
    localparam logic [6:0] LAMPS_WALK = 7'b100_100_1;
    localparam logic [6:0] LAMPS_NSG  = 7'b001_100_0;
    localparam logic [6:0] LAMPS_NSY  = 7'b010_100_0;
    localparam logic [6:0] LAMPS_EWG  = 7'b100_001_0;
    localparam logic [6:0] LAMPS_EWY  = 7'b100_010_0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ped_pending_q, ped_pending_d;
    logic [6:0]       lamps_q, lamps_d;
    logic             in_walk, entering_walk;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (enable) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                case (state_q)
                    CLR_NS: begin
                        if (ped_pending_q) begin
                            state_d = WALK_NS;
                            cnt_d   = WALK_LD;
                        end else begin
                            state_d = NS_GRN;
                            cnt_d   = GREEN_LD;
                        end
                    end
                    WALK_NS: begin
                        state_d = NS_GRN;
                        cnt_d   = GREEN_LD;
                    end
                    NS_GRN: begin
                        if (sense_ew || ped_pending_q) begin
                            state_d = NS_YEL;
                            cnt_d   = YELLOW_LD;
                        end
                    end
                    NS_YEL: begin
                        state_d = CLR_EW;
                        cnt_d   = ALLRED_LD;
                    end
                    CLR_EW: begin
                        if (ped_pending_q) begin
                            state_d = WALK_EW;
                            cnt_d   = WALK_LD;
                        end else begin
                            state_d = EW_GRN;
                            cnt_d   = GREEN_LD;
                        end
                    end
                    WALK_EW: begin
                        state_d = EW_GRN;
                        cnt_d   = GREEN_LD;
                    end
                    EW_GRN: begin
                        if (sense_ns || ped_pending_q) begin
                            state_d = EW_YEL;
                            cnt_d   = YELLOW_LD;
                        end
                    end
                    EW_YEL: begin
                        state_d = CLR_NS;
                        cnt_d   = ALLRED_LD;
                    end
                    default: begin
                        state_d = CLR_NS;
                        cnt_d   = ALLRED_LD;
                    end
                endcase
            end
        end
    end

    // The request is consumed by the WALK it triggers; a press during WALK is dropped.
    always_comb begin
        in_walk       = (state_q == WALK_NS) || (state_q == WALK_EW);
        entering_walk = ((state_d == WALK_NS) || (state_d == WALK_EW)) && (state_d != state_q);
        if (entering_walk) begin
            ped_pending_d = 1'b0;
        end else begin
            ped_pending_d = ped_pending_q | (ped_req & ~in_walk);
        end
    end

    always_comb begin
        lamps_d = LAMPS_CLR;
        case (state_d)
            CLR_NS, CLR_EW:   lamps_d = LAMPS_CLR;
            WALK_NS, WALK_EW: lamps_d = LAMPS_WALK;
            NS_GRN:           lamps_d = LAMPS_NSG;
            NS_YEL:           lamps_d = LAMPS_NSY;
            EW_GRN:           lamps_d = LAMPS_EWG;
            EW_YEL:           lamps_d = LAMPS_EWY;
            default:          lamps_d = LAMPS_CLR;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= CLR_NS;
            cnt_q         <= ALLRED_LD;
            ped_pending_q <= 1'b0;
            lamps_q       <= LAMPS_CLR;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ped_pending_q <= ped_pending_d;
            lamps_q       <= lamps_d;
        end
    end

    assign {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk} = lamps_q;
    assign ped_pending = ped_pending_q;

endmodule
